// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, ALU select codes, instruction fields and decode table
package cpu_pkg;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_MULT  = 8'h08;
  localparam logic [7:0] OP_SLL   = 8'h09;
  localparam logic [7:0] OP_SRA   = 8'h0A;
  localparam logic [7:0] OP_ROR   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;

  typedef enum logic [2:0] {
    ALU_FWD  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_MULT = 3'b100,
    ALU_SL   = 3'b101,
    ALU_SRA  = 3'b110,
    ALU_ROR  = 3'b111
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    write_en;
    logic    imm_sel;
    logic    neg_sel;
    logic    is_jump;
    logic    is_beq;
    logic    is_bne;
    logic    illegal;
  } ctrl_t;

  // Undefined opcodes fall through to a NOP with only the illegal bit set.
  function automatic ctrl_t decode_op(input logic [7:0] op);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_FWD;
    case (op)
      OP_LOADI: begin c.write_en = 1'b1; c.imm_sel = 1'b1; end
      OP_MOV:   begin c.write_en = 1'b1; end
      OP_ADD:   begin c.alu_op = ALU_ADD; c.write_en = 1'b1; end
      OP_SUB:   begin c.alu_op = ALU_ADD; c.write_en = 1'b1; c.neg_sel = 1'b1; end
      OP_AND:   begin c.alu_op = ALU_AND; c.write_en = 1'b1; end
      OP_OR:    begin c.alu_op = ALU_OR; c.write_en = 1'b1; end
      OP_J:     begin c.is_jump = 1'b1; end
      OP_BEQ:   begin c.alu_op = ALU_ADD; c.neg_sel = 1'b1; c.is_beq = 1'b1; end
      OP_MULT:  begin c.alu_op = ALU_MULT; c.write_en = 1'b1; end
      OP_SLL:   begin c.alu_op = ALU_SL; c.write_en = 1'b1; c.imm_sel = 1'b1; end
      OP_SRA:   begin c.alu_op = ALU_SRA; c.write_en = 1'b1; c.imm_sel = 1'b1; end
      OP_ROR:   begin c.alu_op = ALU_ROR; c.write_en = 1'b1; c.imm_sel = 1'b1; end
      OP_BNE:   begin c.alu_op = ALU_ADD; c.neg_sel = 1'b1; c.is_bne = 1'b1; end
      default:  begin c.illegal = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with sequential and branch-target next-PC
module pc_unit #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic                take_target,
  input  logic [7:0]          offset,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] offset_ext;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] next_pc;

  // Word offset: sign-extend the 8-bit field and scale by 4.
  assign pc_plus4      = pc + PC_WIDTH'(4);
  assign offset_ext    = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
  assign branch_target = pc_plus4 + offset_ext;
  assign next_pc       = take_target ? branch_target : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (advance) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - instruction decoder, PC owner, illegal flag and retire counter
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          INSTRUCTION,
  input  logic                 ZERO,
  input  logic                 BUSYWAIT,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [2:0]           ALUOP,
  output logic                 WRITEENABLE,
  output logic                 IMM_SEL,
  output logic                 NEG_SEL,
  output logic                 ILLEGAL,
  output logic [CNT_WIDTH-1:0] RETIRED
);

  logic [7:0] opcode;
  logic [7:0] offset;
  ctrl_t      ctrl;
  logic       take_target;
  logic       retire;
  logic       unused_fields;

  assign opcode        = INSTRUCTION[OP_MSB:OP_LSB];
  assign offset        = INSTRUCTION[DEST_MSB:DEST_LSB];
  assign unused_fields = ^{INSTRUCTION[SRC1_MSB:SRC1_LSB], INSTRUCTION[SRC2_MSB:SRC2_LSB]};

  assign ctrl = decode_op(opcode);

  assign ALUOP       = ctrl.alu_op;
  assign IMM_SEL     = ctrl.imm_sel;
  assign NEG_SEL     = ctrl.neg_sel;
  assign WRITEENABLE = ctrl.write_en & ~BUSYWAIT & ~RESET;

  // ZERO is sampled at the retiring edge, so branches resolve with no delay slot.
  assign take_target = ctrl.is_jump | (ctrl.is_beq & ZERO) | (ctrl.is_bne & ~ZERO);
  assign retire      = ~BUSYWAIT;

  pc_unit #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_unit (
    .clk        (CLK),
    .reset      (RESET),
    .advance    (retire),
    .take_target(take_target),
    .offset     (offset),
    .pc         (PC)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ILLEGAL <= 1'b0;
      RETIRED <= '0;
    end else if (retire) begin
      if (ctrl.illegal) begin
        ILLEGAL <= 1'b1;
      end
      if (RETIRED != {CNT_WIDTH{1'b1}}) begin
        RETIRED <= RETIRED + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed and randomized bench with reference model
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        busy;
  logic [31:0] pc;
  logic [2:0]  aluop;
  logic        we;
  logic        imm_sel;
  logic        neg_sel;
  logic        illegal;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic        m_ill;

  // {aluop, imm_sel, neg_sel, writeenable} for opcodes 0x00..0x0C
  logic [5:0] dec_tab [13];

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_WIDTH(32), .CNT_WIDTH(16)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .INSTRUCTION(instr),
    .ZERO       (zero),
    .BUSYWAIT   (busy),
    .PC         (pc),
    .ALUOP      (aluop),
    .WRITEENABLE(we),
    .IMM_SEL    (imm_sel),
    .NEG_SEL    (neg_sel),
    .ILLEGAL    (illegal),
    .RETIRED    (retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] off);
    return {op, off, 8'h01, 8'h02};
  endfunction

  task automatic step(input logic [31:0] i, input logic z, input logic b, input logic r);
    logic [7:0] op;
    logic [7:0] off;
    int         soff;
    bit         taken;
    op  = i[31:24];
    off = i[23:16];
    @(negedge clk);
    instr = i; zero = z; busy = b; rst = r;
    #1;
    if (op <= 8'h0C) begin
      if (op != 8'h06) chk("aluop", 32'(aluop), 32'(dec_tab[op][5:3]));
      chk("imm_sel", 32'(imm_sel), 32'(dec_tab[op][2]));
      chk("neg_sel", 32'(neg_sel), 32'(dec_tab[op][1]));
      chk("we", 32'(we), 32'(dec_tab[op][0] & ~b & ~r));
    end else begin
      chk("nop_aluop", 32'(aluop), 32'd0);
      chk("nop_we", 32'(we), 32'd0);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 0; m_ret = 0; m_ill = 0;
    end else if (!b) begin
      soff  = int'($signed(off));
      taken = (op == 8'h06) || (op == 8'h07 && z) || (op == 8'h0C && !z);
      m_pc  = taken ? m_pc + 32'(4 + soff * 4) : m_pc + 32'd4;
      if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      if (op > 8'h0C) m_ill = 1'b1;
    end
    chk("pc", pc, m_pc);
    chk("retired", 32'(retired), 32'(m_ret));
    chk("illegal", 32'(illegal), 32'(m_ill));
  endtask

  initial begin
    logic [15:0] saved;
    logic [7:0]  rop;
    dec_tab = '{6'b000_101, 6'b000_001, 6'b001_001, 6'b001_011, 6'b010_001,
                6'b011_001, 6'b000_000, 6'b001_010, 6'b100_001, 6'b101_101,
                6'b110_101, 6'b111_101, 6'b001_010};
    instr = 32'h02030102; zero = 0; busy = 0; rst = 1;
    m_pc = 0; m_ret = 0; m_ill = 0;

    // reset held two cycles with an add on the bus
    step(32'h02030102, 0, 0, 1);
    step(32'h02030102, 0, 0, 1);
    chk("reset_pc", pc, 32'h0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);

    // decode sweep of all defined opcodes
    step(ins(8'h02, 8'h00), 0, 0, 1);
    for (int k = 0; k < 13; k++) begin
      step(ins(8'(k), 8'h00), 0, 0, 0);
      chk("sweep_pc", pc, 32'(4 * (k + 1)));
    end
    chk("sweep_retired", 32'(retired), 32'd13);

    // branches from PC=0x10 with OFFSET=-2
    step(ins(8'h02, 8'h00), 0, 0, 1);
    for (int k = 0; k < 4; k++) step(ins(8'h02, 8'h00), 0, 0, 0);
    step(ins(8'h07, 8'hFE), 1, 0, 0);
    chk("beq_z1_pc", pc, 32'h0C);
    step(ins(8'h02, 8'h00), 0, 0, 0);
    step(ins(8'h07, 8'hFE), 0, 0, 0);
    chk("beq_z0_pc", pc, 32'h14);
    step(ins(8'h06, 8'hFE), 0, 0, 0);
    step(ins(8'h0C, 8'hFE), 1, 0, 0);
    chk("bne_z1_pc", pc, 32'h14);
    step(ins(8'h06, 8'hFE), 0, 0, 0);
    step(ins(8'h0C, 8'hFE), 0, 0, 0);
    chk("bne_z0_pc", pc, 32'h0C);

    // jump and PC wrap
    step(ins(8'h02, 8'h00), 0, 0, 1);
    for (int k = 0; k < 8; k++) step(ins(8'h02, 8'h00), 0, 0, 0);
    chk("pre_jump_pc", pc, 32'h20);
    step(ins(8'h06, 8'h03), 0, 0, 0);
    chk("jump_pc", pc, 32'h30);
    step(ins(8'h02, 8'h00), 0, 0, 1);
    step(ins(8'h06, 8'hFE), 0, 0, 0);
    chk("pre_wrap_pc", pc, 32'hFFFFFFFC);
    step(ins(8'h02, 8'h00), 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);

    // stall during loadi at PC=0x08
    step(ins(8'h02, 8'h00), 0, 0, 1);
    step(ins(8'h02, 8'h00), 0, 0, 0);
    step(ins(8'h02, 8'h00), 0, 0, 0);
    saved = retired;
    for (int k = 0; k < 3; k++) begin
      step(ins(8'h00, 8'h05), 0, 1, 0);
      chk("stall_pc", pc, 32'h08);
      chk("stall_we", 32'(we), 32'd0);
      chk("stall_retired", 32'(retired), 32'(saved));
    end
    step(ins(8'h00, 8'h05), 0, 0, 0);
    chk("release_pc", pc, 32'h0C);
    chk("release_retired", 32'(retired), 32'(saved + 16'd1));

    // illegal opcode, stalled then retired, then reset during a stall
    step(ins(8'h02, 8'h00), 0, 0, 1);
    step(ins(8'h02, 8'h00), 0, 0, 0);
    step(ins(8'hFF, 8'h00), 0, 1, 0);
    chk("illegal_stalled", 32'(illegal), 32'd0);
    step(ins(8'hFF, 8'h00), 0, 0, 0);
    chk("illegal_set", 32'(illegal), 32'd1);
    chk("illegal_pc", pc, 32'h08);
    step(ins(8'h02, 8'h00), 0, 0, 0);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    step(ins(8'h07, 8'h10), 1, 1, 1);
    chk("reset_stall_pc", pc, 32'h0);
    chk("reset_stall_illegal", 32'(illegal), 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rop = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(13, 255)) : 8'($urandom_range(0, 12));
      step({rop, 8'($urandom), 16'($urandom)}, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
